sprite_compositor: RTL and testbench
====================================

# sprite_compositor

Pipelined, parametrised pixel compositor that sits between the sprite/position logic and the VGA output stage, replacing the single-fruit color mapper. For each pixel it tests up to N_SPRITES square sprites, applies a transparency key, resolves overlap by fixed priority, and overlays a per-sprite "slice flash" effect timed in frames. RGB, the winning sprite id and a valid flag are registered two cycles after the pixel coordinate is presented.

## Interface
- N_SPRITES, 4: number of sprite layers (2..8); index 0 is topmost.
- COORD_W, 10: width of DrawX/DrawY, sprite positions and sizes.
- COLOR_W, 4: per-channel width of sprite and background colour inputs.
- KEY_RGB, 12'h0F0: packed {R,G,B} sprite colour treated as transparent (width 3*COLOR_W).
- FLASH_FRAMES, 6: number of frames a triggered sprite renders in flash colour (1..255).
- Clk  in  1  pixel clock.
- Reset_n  in  1  asynchronous, active-low reset.
- pix_valid  in  1  DrawX/DrawY/colour inputs are valid this cycle.
- DrawX, DrawY  in  COORD_W each  current pixel coordinate.
- SpriteX, SpriteY, SpriteSize  in  N_SPRITES*COORD_W each  top-left corner and edge length; sprite i at bits [i*COORD_W +: COORD_W].
- sprite_en  in  N_SPRITES  per-sprite enable.
- SpriteRGB  in  N_SPRITES*3*COLOR_W  per-sprite texel {R,G,B} for this pixel, sprite i at [i*3*COLOR_W +: 3*COLOR_W].
- BKG_RGB  in  3*COLOR_W  background texel {R,G,B}.
- frame_start  in  1  one-cycle pulse per frame.
- flash_trig  in  N_SPRITES  one-cycle pulses starting a flash on sprite i.
- Red, Green, Blue  out  8 each  composited colour.
- hit_any  out  1  a non-transparent enabled sprite won this pixel.
- top_id  out  clog2(N_SPRITES)  index of winning sprite; 0 when hit_any=0.
- pix_valid_o  out  1  outputs correspond to a valid input pixel.

## Operation
- Hit test (stage 1), per sprite i, computed in COORD_W+1 bits: hit_i = sprite_en[i] & (DrawX >= X_i) & (DrawX - X_i < Size_i) & same for Y. No wrap-around: a sprite extending past 2^COORD_W-1 is clipped, never reappears at 0. Size_i=0 never hits.
- Opaque_i = hit_i & (SpriteRGB_i != KEY_RGB).
- Stage 1 registers opaque vector, all sprite texels, background texel, flash-active vector (flash_cnt_i != 0), pix_valid.
- Stage 2: lowest index i with opaque_i wins. Winner colour = 8'hFF on all channels if its flash-active bit set, else texel. No winner: background, hit_any=0, top_id=0.
- Channel expansion COLOR_W->8: replicate MSB-first ({c,c} for COLOR_W=4); COLOR_W=8 passes through.
- Flash counters (8 bit each): flash_trig[i] loads FLASH_FRAMES; else frame_start decrements when non-zero; saturates at 0. Trigger and frame_start same cycle: load wins. Re-trigger during flash reloads FLASH_FRAMES.
- pix_valid=0: stage data still propagates; pix_valid_o=0 and RGB forced to 0 (blanking).

## Timing
- Latency exactly 2 Clk from inputs to Red/Green/Blue/hit_any/top_id/pix_valid_o; throughput one pixel per cycle, no stalls.
- Flash-active is sampled in stage 1: a trigger at cycle t affects pixels presented at t+1 onward (output at t+3).
- Reset_n low (async, any time): both pipeline stages cleared, all outputs 0, all flash counters 0. First valid output appears 2 cycles after first pix_valid following reset release.

## Test plan
- Single sprite: N=4, sprite 2 at (100,50) size 32, texel 12'hF00, BKG 12'h00F; DrawX=100,DrawY=50 -> 2 cycles later RGB=FF/00/00, hit_any=1, top_id=2; DrawX=132 -> RGB=00/00/FF, hit_any=0.
- Overlap priority: sprites 1 and 3 both cover (200,200), texels 12'h0FF / 12'hFF0 -> RGB=00/FF/FF, top_id=1; sprite 1 texel set to KEY 12'h0F0 -> RGB=FF/FF/00, top_id=3.
- Clipping: sprite 0 at X=1020 size 16, DrawX=2 on its row -> background, hit_any=0; DrawX=1023 -> hit.
- Flash: flash_trig[0] pulse, then 6 frame_start pulses -> sprite 0 pixels FF/FF/FF until 6th pulse, texel colour afterwards; trig coinciding with frame_start leaves counter=6.
- Streaming/blanking: back-to-back pixels with alternating pix_valid -> outputs match per-pixel model at latency 2, RGB=0 whenever pix_valid_o=0.
- Async reset mid-stream and mid-flash -> outputs 0 immediately without a Clk edge, counters 0, next pixels render without flash.

Source files
------------

// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: per-sprite hit/transparency test and flash timer in
// stage 1, fixed-priority resolve, flash overlay and colour expansion in stage 2.

module sprite_lane #(
    parameter int                 COORD_W      = 10,
    parameter int                 COLOR_W      = 4,
    parameter logic [3*COLOR_W-1:0] KEY_RGB    = 12'h0F0,
    parameter int                 FLASH_FRAMES = 6
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [COORD_W-1:0]     draw_x_i,
    input  logic [COORD_W-1:0]     draw_y_i,
    input  logic [COORD_W-1:0]     pos_x_i,
    input  logic [COORD_W-1:0]     pos_y_i,
    input  logic [COORD_W-1:0]     size_i,
    input  logic                   en_i,
    input  logic [3*COLOR_W-1:0]   texel_i,
    input  logic                   frame_start_i,
    input  logic                   trig_i,
    output logic                   opaque_o,
    output logic                   flash_act_o
);
    logic [COORD_W:0] dx, dy;
    logic             hit;
    logic [7:0]       flash_cnt_q, flash_cnt_d;

    // Offsets are one bit wider so a sprite running off the right/bottom edge clips
    // instead of wrapping back to coordinate 0.
    assign dx  = {1'b0, draw_x_i} - {1'b0, pos_x_i};
    assign dy  = {1'b0, draw_y_i} - {1'b0, pos_y_i};
    assign hit = en_i && (draw_x_i >= pos_x_i) && (dx < {1'b0, size_i})
                      && (draw_y_i >= pos_y_i) && (dy < {1'b0, size_i});

    assign opaque_o    = hit && (texel_i != KEY_RGB);
    assign flash_act_o = (flash_cnt_q != 8'd0);

    always_comb begin
        flash_cnt_d = flash_cnt_q;
        if (trig_i)
            flash_cnt_d = 8'(FLASH_FRAMES);
        else if (frame_start_i && flash_cnt_q != 8'd0)
            flash_cnt_d = flash_cnt_q - 8'd1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) flash_cnt_q <= 8'd0;
        else          flash_cnt_q <= flash_cnt_d;
    end
endmodule

module sprite_compositor #(
    parameter int                   N_SPRITES    = 4,
    parameter int                   COORD_W      = 10,
    parameter int                   COLOR_W      = 4,
    parameter logic [3*COLOR_W-1:0] KEY_RGB      = 12'h0F0,
    parameter int                   FLASH_FRAMES = 6,
    localparam int                  ID_W         = $clog2(N_SPRITES)
) (
    input  logic                             Clk,
    input  logic                             Reset_n,
    input  logic                             pix_valid,
    input  logic [COORD_W-1:0]               DrawX,
    input  logic [COORD_W-1:0]               DrawY,
    input  logic [N_SPRITES*COORD_W-1:0]     SpriteX,
    input  logic [N_SPRITES*COORD_W-1:0]     SpriteY,
    input  logic [N_SPRITES*COORD_W-1:0]     SpriteSize,
    input  logic [N_SPRITES-1:0]             sprite_en,
    input  logic [N_SPRITES*3*COLOR_W-1:0]   SpriteRGB,
    input  logic [3*COLOR_W-1:0]             BKG_RGB,
    input  logic                             frame_start,
    input  logic [N_SPRITES-1:0]             flash_trig,
    output logic [7:0]                       Red,
    output logic [7:0]                       Green,
    output logic [7:0]                       Blue,
    output logic                             hit_any,
    output logic [ID_W-1:0]                  top_id,
    output logic                             pix_valid_o
);
    logic [N_SPRITES-1:0]                opaque_w, flash_w;
    logic [N_SPRITES-1:0]                opaque_q, flash_q;
    logic [N_SPRITES-1:0][3*COLOR_W-1:0] texel_q;
    logic [3*COLOR_W-1:0]                bkg_q;
    logic [1:0]                          vld_pipe_q;

    logic [3*COLOR_W-1:0] sel;
    logic                 hit_d, flash_d;
    logic [ID_W-1:0]      id_d;
    logic [23:0]          rgb_d, rgb_q;
    logic                 hit_q;
    logic [ID_W-1:0]      id_q;

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_lane
        sprite_lane #(
            .COORD_W(COORD_W), .COLOR_W(COLOR_W),
            .KEY_RGB(KEY_RGB), .FLASH_FRAMES(FLASH_FRAMES)
        ) u_lane (
            .Clk          (Clk),
            .Reset_n      (Reset_n),
            .draw_x_i     (DrawX),
            .draw_y_i     (DrawY),
            .pos_x_i      (SpriteX[g*COORD_W +: COORD_W]),
            .pos_y_i      (SpriteY[g*COORD_W +: COORD_W]),
            .size_i       (SpriteSize[g*COORD_W +: COORD_W]),
            .en_i         (sprite_en[g]),
            .texel_i      (SpriteRGB[g*3*COLOR_W +: 3*COLOR_W]),
            .frame_start_i(frame_start),
            .trig_i       (flash_trig[g]),
            .opaque_o     (opaque_w[g]),
            .flash_act_o  (flash_w[g])
        );
    end

    function automatic logic [7:0] expand(input logic [COLOR_W-1:0] c);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[7-b] = c[COLOR_W-1 - (b % COLOR_W)];
        return r;
    endfunction

    // Walk from the bottom layer up so the lowest opaque index is left selected.
    always_comb begin
        hit_d   = 1'b0;
        flash_d = 1'b0;
        id_d    = '0;
        sel     = bkg_q;
        for (int i = N_SPRITES-1; i >= 0; i--) begin
            if (opaque_q[i]) begin
                hit_d   = 1'b1;
                flash_d = flash_q[i];
                id_d    = ID_W'(i);
                sel     = texel_q[i];
            end
        end
        rgb_d = {expand(sel[3*COLOR_W-1 -: COLOR_W]),
                 expand(sel[2*COLOR_W-1 -: COLOR_W]),
                 expand(sel[COLOR_W-1:0])};
        if (hit_d && flash_d) rgb_d = '1;
        if (!vld_pipe_q[0])   rgb_d = '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            opaque_q   <= '0;
            flash_q    <= '0;
            texel_q    <= '0;
            bkg_q      <= '0;
            vld_pipe_q <= '0;
            rgb_q      <= '0;
            hit_q      <= 1'b0;
            id_q       <= '0;
        end else begin
            opaque_q   <= opaque_w;
            flash_q    <= flash_w;
            texel_q    <= SpriteRGB;
            bkg_q      <= BKG_RGB;
            vld_pipe_q <= {vld_pipe_q[0], pix_valid};
            rgb_q      <= rgb_d;
            hit_q      <= hit_d;
            id_q       <= id_d;
        end
    end

    assign Red         = rgb_q[23:16];
    assign Green       = rgb_q[15:8];
    assign Blue        = rgb_q[7:0];
    assign hit_any     = hit_q;
    assign top_id      = id_q;
    assign pix_valid_o = vld_pipe_q[1];
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: priority, clipping, flash timing, blanking, async reset.

module tb_sprite_compositor;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        pix_valid = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic [39:0] SpriteX = '0, SpriteY = '0, SpriteSize = '0;
    logic [3:0]  sprite_en = '0, flash_trig = '0;
    logic [47:0] SpriteRGB = '0;
    logic [11:0] BKG_RGB = 12'h00F;
    logic        frame_start = 1'b0;
    logic [7:0]  Red, Green, Blue;
    logic        hit_any, pix_valid_o;
    logic [1:0]  top_id;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [27:0] obs;
    assign obs = {Red, Green, Blue, hit_any, top_id, pix_valid_o};

    always #5 Clk = ~Clk;

    sprite_compositor #(
        .N_SPRITES(4), .COORD_W(10), .COLOR_W(4), .KEY_RGB(12'h0F0), .FLASH_FRAMES(6)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY),
        .SpriteX(SpriteX), .SpriteY(SpriteY), .SpriteSize(SpriteSize),
        .sprite_en(sprite_en), .SpriteRGB(SpriteRGB), .BKG_RGB(BKG_RGB),
        .frame_start(frame_start), .flash_trig(flash_trig),
        .Red(Red), .Green(Green), .Blue(Blue),
        .hit_any(hit_any), .top_id(top_id), .pix_valid_o(pix_valid_o)
    );

    function automatic logic [27:0] ex(input logic [23:0] rgb, input logic h,
                                       input logic [1:0] id, input logic v);
        return {rgb, h, id, v};
    endfunction

    task automatic set_sprite(input int i, input int x, input int y, input int sz,
                              input logic [11:0] rgb);
        SpriteX[i*10 +: 10]    = 10'(x);
        SpriteY[i*10 +: 10]    = 10'(y);
        SpriteSize[i*10 +: 10] = 10'(sz);
        SpriteRGB[i*12 +: 12]  = rgb;
        sprite_en[i]           = 1'b1;
    endtask

    task automatic present(input int x, input int y, input logic v);
        @(negedge Clk);
        DrawX = 10'(x); DrawY = 10'(y); pix_valid = v;
    endtask

    task automatic wait_out();
        repeat (2) @(negedge Clk);
    endtask

    task automatic pulse_fs();
        @(negedge Clk); frame_start = 1'b1;
        @(negedge Clk); frame_start = 1'b0;
    endtask

    task automatic pulse_trig(input logic [3:0] m);
        @(negedge Clk); flash_trig = m;
        @(negedge Clk); flash_trig = '0;
    endtask

    task automatic test_reset();
        #2 Reset_n = 1'b0;
        #1;
        total_cnt++;
        if (obs !== 28'h0) $display("FAIL reset_outputs got=%h exp=%h", obs, 28'h0);
        else pass_cnt++;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        total_cnt++;
        if (obs !== 28'h0) $display("FAIL reset_idle got=%h exp=%h", obs, 28'h0);
        else pass_cnt++;
    endtask

    task automatic test_single();
        sprite_en = '0;
        BKG_RGB = 12'h00F;
        set_sprite(2, 100, 50, 32, 12'hF00);
        present(100, 50, 1'b1); wait_out();
        total_cnt++;
        if (obs !== ex(24'hFF0000, 1, 2, 1)) $display("FAIL single_hit got=%h exp=%h", obs, ex(24'hFF0000, 1, 2, 1));
        else pass_cnt++;
        present(132, 50, 1'b1); wait_out();
        total_cnt++;
        if (obs !== ex(24'h0000FF, 0, 0, 1)) $display("FAIL single_right_edge got=%h exp=%h", obs, ex(24'h0000FF, 0, 0, 1));
        else pass_cnt++;
        present(131, 81, 1'b1); wait_out();
        total_cnt++;
        if (obs !== ex(24'hFF0000, 1, 2, 1)) $display("FAIL single_corner got=%h exp=%h", obs, ex(24'hFF0000, 1, 2, 1));
        else pass_cnt++;
        present(100, 49, 1'b1); wait_out();
        total_cnt++;
        if (obs !== ex(24'h0000FF, 0, 0, 1)) $display("FAIL single_above got=%h exp=%h", obs, ex(24'h0000FF, 0, 0, 1));
        else pass_cnt++;
    endtask

    task automatic test_overlap();
        sprite_en = '0;
        set_sprite(1, 190, 190, 20, 12'h0FF);
        set_sprite(3, 195, 195, 10, 12'hFF0);
        present(200, 200, 1'b1); wait_out();
        total_cnt++;
        if (obs !== ex(24'h00FFFF, 1, 1, 1)) $display("FAIL overlap_prio got=%h exp=%h", obs, ex(24'h00FFFF, 1, 1, 1));
        else pass_cnt++;
        SpriteRGB[1*12 +: 12] = 12'h0F0;
        present(200, 200, 1'b1); wait_out();
        total_cnt++;
        if (obs !== ex(24'hFFFF00, 1, 3, 1)) $display("FAIL overlap_key got=%h exp=%h", obs, ex(24'hFFFF00, 1, 3, 1));
        else pass_cnt++;
    endtask

    task automatic test_clip();
        sprite_en = '0;
        set_sprite(0, 1020, 300, 16, 12'h8A4);
        present(2, 305, 1'b1); wait_out();
        total_cnt++;
        if (obs !== ex(24'h0000FF, 0, 0, 1)) $display("FAIL clip_nowrap got=%h exp=%h", obs, ex(24'h0000FF, 0, 0, 1));
        else pass_cnt++;
        present(1023, 305, 1'b1); wait_out();
        total_cnt++;
        if (obs !== ex(24'h88AA44, 1, 0, 1)) $display("FAIL clip_edge_hit got=%h exp=%h", obs, ex(24'h88AA44, 1, 0, 1));
        else pass_cnt++;
        SpriteSize[0 +: 10] = 10'd0;
        present(1020, 300, 1'b1); wait_out();
        total_cnt++;
        if (obs !== ex(24'h0000FF, 0, 0, 1)) $display("FAIL size_zero got=%h exp=%h", obs, ex(24'h0000FF, 0, 0, 1));
        else pass_cnt++;
        SpriteSize[0 +: 10] = 10'd16;
        sprite_en[0] = 1'b0;
        present(1021, 301, 1'b1); wait_out();
        total_cnt++;
        if (obs !== ex(24'h0000FF, 0, 0, 1)) $display("FAIL disabled got=%h exp=%h", obs, ex(24'h0000FF, 0, 0, 1));
        else pass_cnt++;
    endtask

    task automatic test_flash();
        sprite_en = '0;
        set_sprite(0, 10, 10, 8, 12'h123);
        present(12, 12, 1'b1); wait_out();
        total_cnt++;
        if (obs !== ex(24'h112233, 1, 0, 1)) $display("FAIL flash_idle got=%h exp=%h", obs, ex(24'h112233, 1, 0, 1));
        else pass_cnt++;
        // Trigger in the same cycle as a pixel: that pixel is unflashed, the next one flashes.
        @(negedge Clk); flash_trig = 4'b0001;
        @(negedge Clk); flash_trig = '0;
        @(negedge Clk);
        total_cnt++;
        if (obs !== ex(24'h112233, 1, 0, 1)) $display("FAIL flash_same_cycle got=%h exp=%h", obs, ex(24'h112233, 1, 0, 1));
        else pass_cnt++;
        @(negedge Clk);
        total_cnt++;
        if (obs !== ex(24'hFFFFFF, 1, 0, 1)) $display("FAIL flash_next_pixel got=%h exp=%h", obs, ex(24'hFFFFFF, 1, 0, 1));
        else pass_cnt++;
        repeat (5) pulse_fs();
        wait_out();
        total_cnt++;
        if (obs !== ex(24'hFFFFFF, 1, 0, 1)) $display("FAIL flash_after5 got=%h exp=%h", obs, ex(24'hFFFFFF, 1, 0, 1));
        else pass_cnt++;
        pulse_fs(); wait_out();
        total_cnt++;
        if (obs !== ex(24'h112233, 1, 0, 1)) $display("FAIL flash_after6 got=%h exp=%h", obs, ex(24'h112233, 1, 0, 1));
        else pass_cnt++;
        // Trigger coinciding with frame_start must leave the full count.
        @(negedge Clk); flash_trig = 4'b0001; frame_start = 1'b1;
        @(negedge Clk); flash_trig = '0;      frame_start = 1'b0;
        repeat (5) pulse_fs();
        wait_out();
        total_cnt++;
        if (obs !== ex(24'hFFFFFF, 1, 0, 1)) $display("FAIL flash_coincide_5 got=%h exp=%h", obs, ex(24'hFFFFFF, 1, 0, 1));
        else pass_cnt++;
        pulse_fs(); wait_out();
        total_cnt++;
        if (obs !== ex(24'h112233, 1, 0, 1)) $display("FAIL flash_coincide_6 got=%h exp=%h", obs, ex(24'h112233, 1, 0, 1));
        else pass_cnt++;
        pulse_trig(4'b0001);
        repeat (3) pulse_fs();
        pulse_trig(4'b0001);
        repeat (5) pulse_fs();
        wait_out();
        total_cnt++;
        if (obs !== ex(24'hFFFFFF, 1, 0, 1)) $display("FAIL flash_retrig got=%h exp=%h", obs, ex(24'hFFFFFF, 1, 0, 1));
        else pass_cnt++;
        pulse_fs(); wait_out();
        total_cnt++;
        if (obs !== ex(24'h112233, 1, 0, 1)) $display("FAIL flash_retrig_end got=%h exp=%h", obs, ex(24'h112233, 1, 0, 1));
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int          sx[8]  = '{100, 101, 99, 131, 131, 132, 120, 50};
        int          sy[8]  = '{50, 50, 50, 50, 81, 81, 60, 50};
        logic        sv[8]  = '{1, 0, 1, 0, 1, 0, 1, 1};
        logic [24:0] se[8]  = '{{24'hFF0000, 1'b1}, {24'h0, 1'b0}, {24'h0000FF, 1'b1}, {24'h0, 1'b0},
                                {24'hFF0000, 1'b1}, {24'h0, 1'b0}, {24'hFF0000, 1'b1}, {24'h0000FF, 1'b1}};
        sprite_en = '0;
        BKG_RGB = 12'h00F;
        set_sprite(2, 100, 50, 32, 12'hF00);
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (c >= 2) begin
                total_cnt++;
                if ({Red, Green, Blue, pix_valid_o} !== se[c-2])
                    $display("FAIL stream_px%0d got=%h exp=%h", c-2, {Red, Green, Blue, pix_valid_o}, se[c-2]);
                else pass_cnt++;
            end
            if (c < 8) begin
                DrawX = 10'(sx[c]); DrawY = 10'(sy[c]); pix_valid = sv[c];
            end else begin
                pix_valid = 1'b0;
            end
        end
    endtask

    task automatic test_async_reset();
        sprite_en = '0;
        set_sprite(0, 10, 10, 8, 12'h123);
        pulse_trig(4'b0001);
        present(12, 12, 1'b1); wait_out();
        total_cnt++;
        if (obs !== ex(24'hFFFFFF, 1, 0, 1)) $display("FAIL arst_pre got=%h exp=%h", obs, ex(24'hFFFFFF, 1, 0, 1));
        else pass_cnt++;
        #2 Reset_n = 1'b0;
        #1;
        total_cnt++;
        if (obs !== 28'h0) $display("FAIL arst_immediate got=%h exp=%h", obs, 28'h0);
        else pass_cnt++;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        total_cnt++;
        if (obs !== 28'h0) $display("FAIL arst_first_cycle got=%h exp=%h", obs, 28'h0);
        else pass_cnt++;
        @(negedge Clk);
        total_cnt++;
        if (obs !== ex(24'h112233, 1, 0, 1)) $display("FAIL arst_no_flash got=%h exp=%h", obs, ex(24'h112233, 1, 0, 1));
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overlap();
        test_clip();
        test_flash();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
